// File: rtl/hart_pkg.sv
// hart_pkg: constants and types shared by the heart-rate meter and the
// delta-stress comparator.
//   HART_W     width of the published heart-rate value
//   HART_MAX   saturation ceiling of hart
//   HIST_DEPTH number of windows averaged
//   BEATCNT_W  width of the per-window beat counter and history entries
package hart_pkg;
  localparam int HART_W     = 6;
  localparam int HART_MAX   = 63;
  localparam int HIST_DEPTH = 4;
  localparam int BEATCNT_W  = 8;
  localparam int SUM_W      = BEATCNT_W + $clog2(HIST_DEPTH);

  typedef struct packed {
    logic [HART_W-1:0] hart;
    logic              overflow;
    logic              lost;
  } hart_out_t;

  // Clamp a window average to the published range.
  function automatic logic [HART_W-1:0] sat_hart(input logic [BEATCNT_W-1:0] avg);
    return (avg > BEATCNT_W'(HART_MAX)) ? HART_W'(HART_MAX) : avg[HART_W-1:0];
  endfunction
endpackage

// File: rtl/beat_edge_detect.sv
// beat_edge_detect: brings the asynchronous sensor pulse into the clk domain,
// detects its rising edge and applies a refractory hold-off so contact
// bounce and double peaks count as a single beat.
//   clk         system clock
//   resetSlower async active-high reset
//   beat        raw sensor pulse (asynchronous)
//   accepted    one-clk pulse per accepted beat, 3 clk after the beat rises
module beat_edge_detect
  import hart_pkg::*;
#(
  parameter int REFRACT_CYC = 200
) (
  input  logic clk,
  input  logic resetSlower,
  input  logic beat,
  output logic accepted
);
  localparam int RW = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC) : 1;

  logic          s1, s2, s3;
  logic [RW-1:0] refr_cnt;
  logic          rise, idle;

  assign rise = s2 & ~s3;
  assign idle = (refr_cnt == '0);

  always_ff @(posedge clk or posedge resetSlower) begin
    if (resetSlower) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      accepted <= 1'b0;
      refr_cnt <= '0;
    end else begin
      s1       <= beat;
      s2       <= s1;
      s3       <= s2;
      accepted <= rise & idle;
      // Load on acceptance so the next edge needs REFRACT_CYC clocks of spacing.
      if (rise && idle)
        refr_cnt <= RW'(REFRACT_CYC - 1);
      else if (!idle)
        refr_cnt <= refr_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/hart_rate_meter.sv
// hart_rate_meter: counts accepted heartbeats per measurement window (a fixed
// number of slow_tick pulses), averages the last HIST_DEPTH windows and
// publishes a saturated rate with overflow and sensor-loss flags.
//   clk         system clock
//   resetSlower async active-high reset
//   slow_tick   one-clk time-base enable
//   beat        raw sensor pulse (asynchronous)
//   hart        averaged rate, saturated to HART_MAX, 0 while lost
//   hart_valid  one-clk pulse on the cycle after each window close
//   overflow    published hart was clamped
//   lost        LOSS_WINDOWS or more consecutive empty windows
module hart_rate_meter
  import hart_pkg::*;
#(
  parameter int REFRACT_CYC  = 200,
  parameter int WINDOW_TICKS = 15,
  parameter int LOSS_WINDOWS = 2
) (
  input  logic              clk,
  input  logic              resetSlower,
  input  logic              slow_tick,
  input  logic              beat,
  output logic [HART_W-1:0] hart,
  output logic              hart_valid,
  output logic              overflow,
  output logic              lost
);
  localparam logic [7:0] TICK_LAST = 8'(WINDOW_TICKS - 1);
  localparam logic [2:0] EMPTY_MAX = '1;

  logic                                  accepted;
  logic                                  close;
  logic [7:0]                            tick_cnt;
  logic [BEATCNT_W-1:0]                  beat_cnt;
  logic [HIST_DEPTH-1:0][BEATCNT_W-1:0]  hist, hist_nxt;
  logic [2:0]                            empty_cnt, empty_nxt;
  logic [SUM_W-1:0]                      sum;
  logic [BEATCNT_W-1:0]                  avg;
  hart_out_t                             res_nxt, res_q;

  beat_edge_detect #(.REFRACT_CYC(REFRACT_CYC)) u_edge (
    .clk         (clk),
    .resetSlower (resetSlower),
    .beat        (beat),
    .accepted    (accepted)
  );

  // The result is computed from the post-shift history so it can be
  // registered on the close edge and appear exactly one clk after close.
  always_comb begin
    close    = slow_tick && (tick_cnt == TICK_LAST);
    hist_nxt = {hist[HIST_DEPTH-2:0], beat_cnt};
    sum      = '0;
    for (int i = 0; i < HIST_DEPTH; i++)
      sum = sum + SUM_W'(hist_nxt[i]);
    avg = BEATCNT_W'(sum >> $clog2(HIST_DEPTH));

    if (beat_cnt != '0)
      empty_nxt = '0;
    else if (empty_cnt != EMPTY_MAX)
      empty_nxt = empty_cnt + 3'd1;
    else
      empty_nxt = empty_cnt;

    res_nxt.lost     = (empty_nxt >= 3'(LOSS_WINDOWS));
    res_nxt.overflow = !res_nxt.lost && (avg > BEATCNT_W'(HART_MAX));
    res_nxt.hart     = res_nxt.lost ? '0 : sat_hart(avg);
  end

  always_ff @(posedge clk or posedge resetSlower) begin
    if (resetSlower) begin
      tick_cnt   <= '0;
      beat_cnt   <= '0;
      hist       <= '0;
      empty_cnt  <= '0;
      res_q      <= '0;
      hart_valid <= 1'b0;
    end else begin
      hart_valid <= close;
      if (close)
        tick_cnt <= '0;
      else if (slow_tick)
        tick_cnt <= tick_cnt + 8'd1;

      if (close) begin
        // An edge landing on the close cycle opens the new window.
        beat_cnt  <= accepted ? BEATCNT_W'(1) : '0;
        hist      <= hist_nxt;
        empty_cnt <= empty_nxt;
        res_q     <= res_nxt;
      end else if (accepted && beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign hart     = res_q.hart;
  assign overflow = res_q.overflow;
  assign lost     = res_q.lost;
endmodule

// File: tb/tb_hart_rate_meter.sv
module tb_hart_rate_meter;
  localparam int REFRACT = 20;
  localparam int WTICKS  = 4;
  localparam int LOSSW   = 2;
  localparam int TICK_P  = 500;

  logic       clk = 1'b0;
  logic       resetSlower, slow_tick, beat;
  logic [5:0] hart;
  logic       hart_valid, overflow, lost;

  hart_rate_meter #(.REFRACT_CYC(REFRACT), .WINDOW_TICKS(WTICKS), .LOSS_WINDOWS(LOSSW)) dut (
    .clk(clk), .resetSlower(resetSlower), .slow_tick(slow_tick), .beat(beat),
    .hart(hart), .hart_valid(hart_valid), .overflow(overflow), .lost(lost)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int hart; bit ovf; bit lost; } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: events in absolute cycles, windows as plain lists.
  int tphase, m_ticks, m_last_acc, m_empty;
  int m_hist[4];
  int m_acc[$];
  bit beat_q;
  int hold_h; bit hold_o, hold_l;

  task automatic model_reset();
    tphase = 0; m_ticks = 0; m_last_acc = -1000; m_empty = 0; beat_q = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    m_acc.delete();
    exp_q.delete();
  endtask

  task automatic close_window(input int c);
    int cnt, sum, avg;
    exp_t e;
    cnt = 0;
    while (m_acc.size() > 0 && m_acc[0] < c) begin
      void'(m_acc.pop_front());
      cnt++;
    end
    if (cnt > 255) cnt = 255;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = cnt;
    sum = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
    avg = sum / 4;
    m_empty = (cnt == 0) ? ((m_empty < 7) ? m_empty + 1 : 7) : 0;
    e.cyc  = c + 1;
    e.lost = (m_empty >= LOSSW);
    e.hart = e.lost ? 0 : ((avg > 63) ? 63 : avg);
    e.ovf  = !e.lost && (avg > 63);
    exp_q.push_back(e);
  endtask

  // One clock: drive beat and the time base, feed the model.
  task automatic step(input bit b);
    bit t;
    int a;
    @(posedge clk); #1;
    t = (tphase == TICK_P - 1);
    tphase = t ? 0 : tphase + 1;
    beat = b;
    slow_tick = t;
    if (b && !beat_q) begin
      a = cyc + 3;
      if (a - m_last_acc >= REFRACT) begin
        m_last_acc = a;
        m_acc.push_back(a);
      end
    end
    beat_q = b;
    if (t) begin
      m_ticks++;
      if (m_ticks == WTICKS) begin
        m_ticks = 0;
        close_window(cyc);
      end
    end
  endtask

  task automatic run_window(input int len, input int nbeats, input int spacing,
                            input int start, input int width, input bit bounce);
    int rel, k;
    bit b;
    for (int off = 0; off < len; off++) begin
      b = 0;
      if (off >= start && nbeats > 0) begin
        k   = (off - start) / spacing;
        rel = (off - start) % spacing;
        if (k < nbeats && rel < 10)
          b = bounce ? ((rel / 2) % 2 == 0) : (rel < width);
      end
      step(b);
    end
  endtask

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic chk_out(input string name, input int h, input int o, input int l);
    chk({name, " hart"}, int'(hart), h);
    chk({name, " overflow"}, int'(overflow), o);
    chk({name, " lost"}, int'(lost), l);
  endtask

  // Monitor: pops the scoreboard on every hart_valid, checks hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (resetSlower) begin
      checks++;
      if (hart !== 6'd0 || hart_valid !== 1'b0 || overflow !== 1'b0 || lost !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: hart=%0d valid=%0b ovf=%0b lost=%0b expected all 0",
                 hart, hart_valid, overflow, lost);
      end
      hold_h = 0; hold_o = 0; hold_l = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_valid: no hart_valid at cycle %0d (expected hart=%0d)", e.cyc, e.hart);
        hold_h = e.hart; hold_o = e.ovf; hold_l = e.lost;
      end
      checks++;
      if (hart_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: hart_valid at cycle %0d hart=%0d, none expected", cyc, hart);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || hart !== 6'(e.hart) || overflow !== e.ovf || lost !== e.lost) begin
            errors++;
            $display("FAIL update: cyc=%0d hart=%0d ovf=%0b lost=%0b, expected cyc=%0d hart=%0d ovf=%0b lost=%0b",
                     cyc, hart, overflow, lost, e.cyc, e.hart, e.ovf, e.lost);
          end
          hold_h = e.hart; hold_o = e.ovf; hold_l = e.lost;
        end
      end else if (hart !== 6'(hold_h) || overflow !== hold_o || lost !== hold_l) begin
        errors++;
        $display("FAIL hold: cyc=%0d hart=%0d ovf=%0b lost=%0b, expected hart=%0d ovf=%0b lost=%0b",
                 cyc, hart, overflow, lost, hold_h, hold_o, hold_l);
      end
    end
  end

  initial begin
    int sp, nb;
    resetSlower = 1'b1; beat = 1'b0; slow_tick = 1'b0;
    model_reset();
    #3;
    chk_out("reset", 0, 0, 0);
    chk("reset hart_valid", int'(hart_valid), 0);
    repeat (3) @(posedge clk);
    #1 resetSlower = 1'b0;

    // Steady 5 beats per window: 1, 2, 3, 5, 5.
    for (int w = 0; w < 5; w++) run_window(2000, 5, 400, 100 + $urandom_range(0, 50), 5, 0);
    step(0);
    chk_out("steady", 5, 0, 0);

    // Bounce: three rises within 10 clk, once per window.
    for (int w = 0; w < 4; w++) run_window(2000, 1, 400, 300, 5, 1);
    step(0);
    chk_out("bounce", 1, 0, 0);

    // Saturation: 80 beats spaced 25 clk -> 20, 40, 60, 63 with overflow.
    for (int w = 0; w < 4; w++) run_window(2000, 80, 25, 5, 3, 0);
    step(0);
    chk_out("saturation", 63, 1, 0);

    // Loss: flush with steady windows, two empty windows, then recovery.
    for (int w = 0; w < 4; w++) run_window(2000, 5, 400, 100, 5, 0);
    run_window(2000, 0, 400, 100, 5, 0);
    step(0);
    chk_out("one_empty", 3, 0, 0);
    run_window(2000, 0, 400, 100, 5, 0);
    step(0);
    chk_out("loss", 0, 0, 1);
    run_window(2000, 5, 400, 100, 5, 0);
    step(0);
    chk_out("recover", 2, 0, 0);

    // Simultaneous: one empty window, then a window whose only edge is
    // accepted on the close cycle; it must not rescue that window.
    run_window(2000, 0, 400, 100, 5, 0);
    for (int n = 0; n < 4000 && !(m_ticks == WTICKS - 1 && tphase == TICK_P - 4); n++) step(0);
    chk("simul aligned", int'(m_ticks == WTICKS - 1 && tphase == TICK_P - 4), 1);
    step(1); step(1); step(1); step(0);
    step(0);
    chk_out("simul_close", 0, 0, 1);
    run_window(2000, 0, 400, 100, 5, 0);
    step(0);
    chk_out("simul_next", 1, 0, 0);

    // Randomized windows, spacing straddling the refractory period.
    for (int w = 0; w < 6; w++) begin
      sp = $urandom_range(REFRACT - 3, 400);
      nb = $urandom_range(0, 1850 / sp);
      run_window(2000, nb, sp, 50, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    // Reset 1000 clk into a window: outputs drop at once, partial window lost.
    run_window(1000, 5, 400, 100, 5, 0);
    #2 resetSlower = 1'b1;
    beat = 1'b0; slow_tick = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 0);
    chk("async_reset hart_valid", int'(hart_valid), 0);
    model_reset();
    repeat (4) @(posedge clk);
    #1 resetSlower = 1'b0;
    tphase = TICK_P - 1;   // a tick on the first cycle after release
    run_window(1510, 5, 400, 100, 5, 0);
    chk_out("post_reset", 1, 0, 0);
    run_window(2000, 5, 400, 100, 5, 0);
    sp = $urandom_range(REFRACT, 200);
    run_window(2000, $urandom_range(1, 1800 / sp), sp, 50, 2, 0);

    repeat (10) step(0);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
